uart_rx_word_assembler: RTL
===========================

// Module: uart_rx_word_assembler
// PURPOSE
//  Consumer-side endpoint of the UART receiver's byte interface (Rx_DATA/Rx_VALID/Rx_PERROR/Rx_FERROR).
//  Collects NUM_BYTES consecutive error-free bytes into one word for downstream logic (7-segment driver).
//  Discards a partial word on a line error, an inter-byte timeout or a disable, and reports the cause.
//  Sits beside UART_Receiver inside the UART top, in the same single clock domain.
// PARAMETERS
//  NUM_BYTES    2      bytes per word, 1..4; word width W = 8*NUM_BYTES
//  TIMEOUT_CYC  50000  max Clk cycles between bytes of one word before the partial word is dropped, >=2
// PORTS
//  Clk        in   1   system clock, rising edge
//  reset      in   1   synchronous, active-high
//  en         in   1   assembler enable; low = ignore bytes and flush any partial word
//  Rx_DATA    in   8   received byte, stable while Rx_VALID high
//  Rx_VALID   in   1   receiver byte-valid, may be held high for several cycles
//  Rx_PERROR  in   1   parity error qualifier for the current byte
//  Rx_FERROR  in   1   framing error qualifier for the current byte
//  word_out   out  W   last completed word; first received byte in bits [W-1:W-8]
//  word_valid out  1   1-cycle pulse when word_out updates
//  byte_cnt   out  3   bytes held of the word in progress, 0..NUM_BYTES-1
//  err_pulse  out  1   1-cycle pulse: partial word dropped on a PERROR/FERROR byte
//  tmo_pulse  out  1   1-cycle pulse: partial word dropped on timeout
//  err_sticky out  1   set by err_pulse or tmo_pulse; cleared on the next completed word or reset
// BEHAVIOUR
//  - Reset (synchronous): all outputs 0, shift register 0, state IDLE, timer 0.
//  - Byte event = rising edge of Rx_VALID (registered prev value): Rx_VALID & ~vld_q. A held-high Rx_VALID counts once.
//  - Rx_DATA, Rx_PERROR and Rx_FERROR are sampled in the event cycle.
//  - Good byte = event & ~Rx_PERROR & ~Rx_FERROR. Bad byte = event & (Rx_PERROR | Rx_FERROR).
//  - FSM states:
//    - IDLE:
//      - good byte: shift it in, byte_cnt=1, timer=TIMEOUT_CYC, go to COLLECT.
//      - NUM_BYTES==1: a good byte completes the word immediately; stay in IDLE.
//      - bad byte: err_pulse, stay in IDLE.
//    - COLLECT:
//      - timer decrements every cycle with no event.
//      - good byte: shift it in (left shift by 8, new byte into LSBs), byte_cnt+1, timer reloaded.
//      - the good byte that reaches NUM_BYTES: word_out <= shifted value the next cycle, word_valid=1,
//        err_sticky=0, byte_cnt=0, go to IDLE.
//      - bad byte: drop the partial word, byte_cnt=0, err_pulse, go to IDLE.
//      - timer reaches 0 with no event that cycle: drop the partial word, byte_cnt=0, tmo_pulse, go to IDLE.
//  - Latency: word_valid is high in the cycle after the completing byte event.
//  - Simultaneous event and timer expiry in one cycle: the event wins (good byte accepted, or err_pulse); no tmo_pulse.
//  - en low:
//    - events ignored (vld_q still tracks Rx_VALID).
//    - a partial word is flushed with byte_cnt=0 and no pulses; state goes to IDLE.
//    - word_out is retained.
//  - Reset mid-word: the partial word is lost; word_out is cleared; no pulses are generated.
//  - err_pulse and tmo_pulse are never both high in one cycle. word_valid never coincides with either.
//  - Timer width is $clog2(TIMEOUT_CYC+1) bits, unsigned; it never wraps below 0.
// STRUCTURE
//  - Shared package uart_pkg:
//    - typedef asm_state_t {IDLE, COLLECT}
//    - localparam BYTE_W=8
//  - One sub-module, uart_timeout_timer: load/decrement/expire pulse, parameterised by TIMEOUT_CYC.
//  - Edge detect, shift register and FSM stay in the top.
// TESTING (NUM_BYTES=2, TIMEOUT_CYC=20)
//  1. Bytes 0x12 then 0x34, 5 cycles apart -> word_out=0x1234, word_valid one cycle after the 0x34 event, byte_cnt back to 0.
//  2. Rx_VALID held high 6 cycles with 0xAB -> counted once; byte_cnt=1; no word_valid.
//  3. 0x55 good, then 0x66 with Rx_PERROR=1 -> err_pulse, err_sticky=1, word_out unchanged.
//     Then 0x01, 0x02 -> word_out=0x0102, err_sticky=0.
//  4. 0x77, then no byte for 20 cycles -> tmo_pulse at expiry, byte_cnt=0.
//     Second byte event exactly on the expiry cycle -> accepted, no tmo_pulse.
//  5. 0x9A, then en=0 for 3 cycles, then en=1 and 0xBC -> byte_cnt=1 holding 0xBC, no pulses, word_out unchanged.
//  6. reset asserted after the first byte of a word -> all outputs 0 next cycle.
//     After reset, 0xDE, 0xAD -> word_out=0xDEAD.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART byte-side logic
package uart_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic {IDLE, COLLECT} asm_state_t;
endpackage

// File: rtl/uart_timeout_timer.sv
// uart_timeout_timer: loadable down-counter that flags the cycle it decrements from 1 to 0
module uart_timeout_timer #(
    parameter int TIMEOUT_CYC = 50000,
    localparam int TW = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic Clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic expire
);
    logic [TW-1:0] cnt;
    assign expire = dec && cnt == TW'(1);
    always_ff @(posedge Clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= TW'(TIMEOUT_CYC);
        else if (dec && cnt != '0) cnt <= cnt - TW'(1);
    end
endmodule

// File: rtl/uart_rx_word_assembler.sv
// uart_rx_word_assembler: packs NUM_BYTES error-free received bytes into one word, first byte in the MSBs
module uart_rx_word_assembler import uart_pkg::*; #(
    parameter int NUM_BYTES = 2,
    parameter int TIMEOUT_CYC = 50000,
    localparam int W = BYTE_W * NUM_BYTES
) (
    input  logic         Clk,
    input  logic         reset,
    input  logic         en,
    input  logic [7:0]   Rx_DATA,
    input  logic         Rx_VALID,
    input  logic         Rx_PERROR,
    input  logic         Rx_FERROR,
    output logic [W-1:0] word_out,
    output logic         word_valid,
    output logic [2:0]   byte_cnt,
    output logic         err_pulse,
    output logic         tmo_pulse,
    output logic         err_sticky
);
    asm_state_t state, state_n;
    logic vld_q, ev, good, bad, load, dec, expire;
    logic wv_n, err_n, tmo_n, sticky_n;
    logic [2:0] cnt_n, nb;
    logic [W-1:0] shreg, shreg_n, word_n, base, shifted;

    assign ev = Rx_VALID & ~vld_q & en;
    assign good = ev & ~(Rx_PERROR | Rx_FERROR);
    assign bad = ev & (Rx_PERROR | Rx_FERROR);

    uart_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
        .Clk(Clk), .reset(reset), .load(load), .dec(dec), .expire(expire)
    );

    always_comb begin
        base = (state == IDLE) ? {W{1'b0}} : shreg;
        shifted = (base << BYTE_W) | W'(Rx_DATA);
        nb = ((state == IDLE) ? 3'd0 : byte_cnt) + 3'd1;
        dec = state == COLLECT && en && !ev;
        state_n = state;
        shreg_n = shreg;
        cnt_n = byte_cnt;
        word_n = word_out;
        sticky_n = err_sticky;
        wv_n = 1'b0;
        err_n = 1'b0;
        tmo_n = 1'b0;
        load = 1'b0;
        // Event beats a same-cycle expiry because it is tested first
        if (!en) begin
            state_n = IDLE;
            shreg_n = '0;
            cnt_n = '0;
        end else if (good && nb == 3'(NUM_BYTES)) begin
            state_n = IDLE;
            shreg_n = '0;
            cnt_n = '0;
            word_n = shifted;
            wv_n = 1'b1;
            sticky_n = 1'b0;
        end else if (good) begin
            state_n = COLLECT;
            shreg_n = shifted;
            cnt_n = nb;
            load = 1'b1;
        end else if (bad || expire) begin
            state_n = IDLE;
            shreg_n = '0;
            cnt_n = '0;
            err_n = bad;
            tmo_n = ~bad;
            sticky_n = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= IDLE;
            vld_q <= 1'b0;
            shreg <= '0;
            byte_cnt <= '0;
            word_out <= '0;
            word_valid <= 1'b0;
            err_pulse <= 1'b0;
            tmo_pulse <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_n;
            vld_q <= Rx_VALID;
            shreg <= shreg_n;
            byte_cnt <= cnt_n;
            word_out <= word_n;
            word_valid <= wv_n;
            err_pulse <= err_n;
            tmo_pulse <= tmo_n;
            err_sticky <= sticky_n;
        end
    end
endmodule
